// File: rtl/sd_pkg.sv
// Shared constants and FSM state encoding for the SD file sector generator.
package sd_pkg;

   localparam int NAME_MAX    = 52;
   localparam int SECTOR_LOG2 = 9;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_CALC = 3'd2,
      ST_REQ  = 3'd3,
      ST_WAIT = 3'd4,
      ST_DONE = 3'd5
   } state_e;

endpackage

// File: rtl/sd_name_cmp.sv
// Combinational comparison of a directory entry name against the target name.
module sd_name_cmp #(
   parameter int NAME_MAX = 52
) (
   input  logic [7:0]            i_tlen,
   input  logic [8*NAME_MAX-1:0] i_tname,
   input  logic [7:0]            i_flen,
   input  logic [8*NAME_MAX-1:0] i_fname,
   output logic                  o_match
);

   logic w_eq;

   // Bytes at or beyond the entry length are don't-care.
   always_comb begin
      w_eq = (i_flen == i_tlen);
      for (int i = 0; i < NAME_MAX; i++) begin
         if ((i < int'(i_flen)) && (i_fname[8*i +: 8] != i_tname[8*i +: 8])) begin
            w_eq = 1'b0;
         end
      end
   end

   assign o_match = w_eq;

endmodule

// File: rtl/sd_file_sector_gen.sv
// Scans directory entries for a target file name, then requests the file's
// sectors one at a time as a contiguous run starting at its first cluster.
module sd_file_sector_gen #(
   parameter int NAME_MAX = sd_pkg::NAME_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            tnamelen,
   input  logic [8*NAME_MAX-1:0] tname,
   input  logic                  fready,
   input  logic [7:0]            fnamelen,
   input  logic [8*NAME_MAX-1:0] fname,
   input  logic [15:0]           fcluster,
   input  logic [31:0]           fsize,
   input  logic                  dir_done,
   input  logic [31:0]           data_start,
   input  logic [2:0]            spc_log2,
   output logic                  rd_req,
   output logic [31:0]           rd_sector,
   input  logic                  rd_ack,
   output logic                  busy,
   output logic                  found,
   output logic                  notfound,
   output logic                  err,
   output logic                  done,
   output logic [31:0]           file_size
);

   import sd_pkg::*;

   state_e      r_state;
   logic [15:0] r_fcluster;
   logic [31:0] r_fsize;
   logic [31:0] r_lba;
   logic [23:0] r_count;
   logic [23:0] r_index;
   logic        r_found;
   logic        r_notfound;
   logic        r_err;
   logic        r_done;

   logic        w_match;
   logic [32:0] w_sum;
   logic [23:0] w_count;
   logic [31:0] w_lba;
   logic [23:0] w_index_inc;

   sd_name_cmp #(
      .NAME_MAX (NAME_MAX)
   ) u_name_cmp (
      .i_tlen  (tnamelen),
      .i_tname (tname),
      .i_flen  (fnamelen),
      .i_fname (fname),
      .o_match (w_match)
   );

   // Round up to whole sectors with a carry bit so sizes near 2^32 do not wrap.
   assign w_sum       = {1'b0, r_fsize} + 33'd511;
   assign w_count     = w_sum[32:SECTOR_LOG2];
   assign w_lba       = data_start + (({16'd0, r_fcluster} - 32'd2) << spc_log2);
   assign w_index_inc = r_index + 24'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fcluster <= '0;
         r_fsize    <= '0;
         r_lba      <= '0;
         r_count    <= '0;
         r_index    <= '0;
         r_found    <= 1'b0;
         r_notfound <= 1'b0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state    <= ST_SCAN;
                  r_found    <= 1'b0;
                  r_notfound <= 1'b0;
                  r_err      <= 1'b0;
                  r_done     <= 1'b0;
                  r_lba      <= '0;
                  r_count    <= '0;
                  r_index    <= '0;
               end
            end
            ST_SCAN: begin
               // A match wins over a simultaneous dir_done.
               if (fready && w_match) begin
                  r_fcluster <= fcluster;
                  r_fsize    <= fsize;
                  r_found    <= 1'b1;
                  r_state    <= ST_CALC;
               end else if (dir_done) begin
                  r_notfound <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_CALC: begin
               r_count <= w_count;
               r_lba   <= w_lba;
               r_index <= '0;
               if ((r_fcluster < 16'd2) && (r_fsize != 32'd0)) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_count == 24'd0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (rd_ack) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_lba   <= r_lba + 32'd1;
               r_index <= w_index_inc;
               if (w_index_inc == r_count) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_REQ;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rd_req    = (r_state == ST_REQ);
   assign rd_sector = r_lba;
   assign busy      = (r_state == ST_SCAN) || (r_state == ST_CALC) ||
                      (r_state == ST_REQ)  || (r_state == ST_WAIT);
   assign found     = r_found;
   assign notfound  = r_notfound;
   assign err       = r_err;
   assign done      = r_done;
   assign file_size = r_found ? r_fsize : 32'd0;

endmodule

// File: tb/tb_sd_file_sector_gen.sv
// Directed bench: name scan, sector sequencing, error cases and mid-run reset.
module tb_sd_file_sector_gen;

   localparam int NM = 52;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [7:0]      tnamelen = '0;
   logic [8*NM-1:0] tname = '0;
   logic            fready = 1'b0;
   logic [7:0]      fnamelen = '0;
   logic [8*NM-1:0] fname = '0;
   logic [15:0]     fcluster = '0;
   logic [31:0]     fsize = '0;
   logic            dir_done = 1'b0;
   logic [31:0]     data_start = '0;
   logic [2:0]      spc_log2 = '0;
   logic            rd_req;
   logic [31:0]     rd_sector;
   logic            rd_ack = 1'b0;
   logic            busy, found, notfound, err, done;
   logic [31:0]     file_size;

   int n_pass  = 0;
   int n_total = 0;
   bit req_seen = 1'b0;

   sd_file_sector_gen #(.NAME_MAX(NM)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .tnamelen   (tnamelen),
      .tname      (tname),
      .fready     (fready),
      .fnamelen   (fnamelen),
      .fname      (fname),
      .fcluster   (fcluster),
      .fsize      (fsize),
      .dir_done   (dir_done),
      .data_start (data_start),
      .spc_log2   (spc_log2),
      .rd_req     (rd_req),
      .rd_sector  (rd_sector),
      .rd_ack     (rd_ack),
      .busy       (busy),
      .found      (found),
      .notfound   (notfound),
      .err        (err),
      .done       (done),
      .file_size  (file_size)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rd_req === 1'b1) req_seen = 1'b1;
   endtask

   function automatic logic [8*NM-1:0] mkname(input string s);
      logic [8*NM-1:0] v;
      v = '0;
      for (int i = 0; i < s.len() && i < NM; i++) v[8*i +: 8] = s[i];
      return v;
   endfunction

   task automatic begin_scan(input string t);
      tname    = mkname(t);
      tnamelen = 8'(t.len());
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic entry(input string s, input logic [15:0] cl, input logic [31:0] sz,
                        input logic dd);
      fname    = mkname(s);
      fnamelen = 8'(s.len());
      fcluster = cl;
      fsize    = sz;
      fready   = 1'b1;
      dir_done = dd;
      step();
      fready   = 1'b0;
      dir_done = 1'b0;
   endtask

   task automatic dir_end();
      dir_done = 1'b1;
      step();
      dir_done = 1'b0;
   endtask

   // Wait for a request, check it stays stable for dly cycles, then acknowledge.
   task automatic serve(input logic [31:0] exp, input int dly);
      int k;
      k = 0;
      while (rd_req !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check("req_arrived", 32'(rd_req), 32'd1);
      check("rd_sector", rd_sector, exp);
      for (int c = 0; c < dly; c++) begin
         step();
         check("req_hold", 32'(rd_req), 32'd1);
         check("sector_hold", rd_sector, exp);
      end
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      check("wait_no_req", 32'(rd_req), 32'd0);
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_req", 32'(rd_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_fsize", file_size, 32'd0);
      step();
      rst = 1'b0;

      // Basic three-sector read
      data_start = 32'h1000;
      spc_log2   = 3'd2;
      begin_scan("DATA.BIN");
      check("scan_busy", 32'(busy), 32'd1);
      entry("A.TXT", 16'd9, 32'd100, 1'b0);
      check("nomatch_found", 32'(found), 32'd0);
      entry("DATA.BIN", 16'd5, 32'd1025, 1'b0);
      check("match_found", 32'(found), 32'd1);
      check("match_size", file_size, 32'd1025);
      step();
      serve(32'h100C, 0);
      serve(32'h100D, 0);
      serve(32'h100E, 0);
      step();
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_found", 32'(found), 32'd1);
      step();
      check("t1_no_extra", 32'(rd_req), 32'd0);

      // Target absent, stray rd_ack in SCAN
      req_seen = 1'b0;
      begin_scan("NOPE.BIN");
      check("t2_clear_found", 32'(found), 32'd0);
      check("t2_clear_done", 32'(done), 32'd0);
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      check("stray_ack_busy", 32'(busy), 32'd1);
      entry("A.TXT", 16'd3, 32'd10, 1'b0);
      entry("B.TXT", 16'd4, 32'd10, 1'b0);
      entry("DATA.BIN", 16'd5, 32'd10, 1'b0);
      dir_end();
      check("t2_notfound", 32'(notfound), 32'd1);
      check("t2_done", 32'(done), 32'd1);
      check("t2_found", 32'(found), 32'd0);
      check("t2_no_req", 32'(req_seen), 32'd0);

      // Zero-size match, then cluster-0 error
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd5, 32'd0, 1'b0);
      step();
      check("t3_found", 32'(found), 32'd1);
      check("t3_done", 32'(done), 32'd1);
      check("t3_err", 32'(err), 32'd0);
      check("t3_no_req", 32'(req_seen), 32'd0);
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd0, 32'd10, 1'b0);
      step();
      check("t3_err_set", 32'(err), 32'd1);
      check("t3_err_done", 32'(done), 32'd1);
      check("t3_err_no_req", 32'(req_seen), 32'd0);

      // Delayed acknowledge
      data_start = 32'h2000;
      spc_log2   = 3'd0;
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd2, 32'd512, 1'b0);
      step();
      serve(32'h2000, 7);
      step();
      check("t4_done", 32'(done), 32'd1);

      // Reset during REQ of a four-sector file, then rescan
      data_start = 32'h10;
      spc_log2   = 3'd1;
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd3, 32'd2048, 1'b0);
      step();
      check("t5_in_req", 32'(rd_req), 32'd1);
      check("t5_sector", rd_sector, 32'h12);
      rst = 1'b1;
      #1;
      check("t5_rst_req", 32'(rd_req), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_found", 32'(found), 32'd0);
      check("t5_rst_sector", rd_sector, 32'd0);
      step();
      rst = 1'b0;
      step();
      check("t5_idle", 32'(busy), 32'd0);
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd3, 32'd2048, 1'b0);
      step();
      serve(32'h12, 0);
      serve(32'h13, 0);
      serve(32'h14, 0);
      serve(32'h15, 0);
      step();
      check("t5_done", 32'(done), 32'd1);

      // Match and dir_done in the same cycle
      data_start = 32'h500;
      spc_log2   = 3'd3;
      begin_scan("DATA.BIN");
      entry("DATA.BIN", 16'd2, 32'd1, 1'b1);
      check("t6_found", 32'(found), 32'd1);
      check("t6_notfound", 32'(notfound), 32'd0);
      step();
      serve(32'h500, 0);
      step();
      check("t6_done", 32'(done), 32'd1);
      check("t6_notfound_end", 32'(notfound), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sd_file_sector_gen.md
SD_FILE_SECTOR_GEN -- requirements
Module: sd_file_sector_gen

Interface
REQ-001 SHALL have parameter: NAME_MAX, 52, maximum file-name bytes compared.
REQ-002 SHALL have port: clk  in  1  single clock for all logic.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  one-cycle pulse beginning a directory scan.
REQ-005 SHALL have port: tnamelen  in  8  target name length.
REQ-006 SHALL have port: tname  in  8 x NAME_MAX  target name, upper case.
REQ-007 SHALL have port: fready  in  1  one-cycle pulse, directory entry valid.
REQ-008 SHALL have port: fnamelen  in  8  entry name length.
REQ-009 SHALL have port: fname  in  8 x NAME_MAX  entry name bytes.
REQ-010 SHALL have port: fcluster  in  16  entry first cluster.
REQ-011 SHALL have port: fsize  in  32  entry size in bytes.
REQ-012 SHALL have port: dir_done  in  1  pulse, directory region fully streamed.
REQ-013 SHALL have port: data_start  in  32  LBA of cluster 2.
REQ-014 SHALL have port: spc_log2  in  3  log2 of sectors per cluster (0..7).
REQ-015 SHALL have port: rd_req  out  1  sector read request.
REQ-016 SHALL have port: rd_sector  out  32  LBA requested.
REQ-017 SHALL have port: rd_ack  in  1  requested sector fully delivered.
REQ-018 SHALL have ports: busy, found, notfound, err, done  out  1 each  status.
REQ-019 SHALL have port: file_size  out  32  size of the matched file.

Function
REQ-020 SHALL implement states IDLE, SCAN, CALC, REQ, WAIT, DONE.
REQ-021 IDLE: start -> SCAN, clearing found, notfound, err, done; start outside IDLE and DONE SHALL be ignored.
REQ-022 SCAN: fready with fnamelen==tnamelen and the first fnamelen bytes equal SHALL latch fcluster/fsize, set found, go CALC; the first match wins.
REQ-023 SCAN: dir_done without a match SHALL set notfound and go DONE; a match and dir_done in the same cycle SHALL count as a match.
REQ-024 fready outside SCAN SHALL be ignored.
REQ-025 CALC (one cycle): count = (fsize+511)>>9 computed at 33 bits, 24-bit result; lba = data_start + ((fcluster-2) << spc_log2) at 32 bits, wrapping modulo 2^32.
REQ-026 CALC: fcluster<2 with fsize!=0 SHALL set err and go DONE; count==0 SHALL go DONE with no request.
REQ-027 REQ: rd_req=1 with rd_sector=lba, held stable until rd_ack; rd_ack then SHALL go WAIT.
REQ-028 WAIT (one cycle, rd_req=0): increment lba and the sector index; index==count SHALL go DONE, otherwise REQ.
REQ-029 rd_ack outside REQ SHALL be ignored.
REQ-030 Sectors SHALL be issued contiguously; FAT chain following is out of scope, so only contiguous files are read correctly.
REQ-031 DONE: done=1, busy=0, and statuses held until the next start.
REQ-032 busy SHALL be 1 in SCAN, CALC, REQ, and WAIT.
REQ-033 file_size SHALL show the latched fsize once found, and 0 otherwise.

Reset
REQ-034 rst SHALL force IDLE immediately, at any point mid-operation.
REQ-035 On reset, all outputs, lba, count, and index SHALL be 0, with rd_req dropping combinationally.

Structure
REQ-036 Package sd_pkg SHALL hold NAME_MAX, SECTOR_LOG2=9, and the state enum.
REQ-037 Sub-module sd_name_cmp SHALL compare name and length combinationally into a single match bit.

Verification
REQ-038 Target "DATA.BIN" (len 8), entries "A.TXT" then "DATA.BIN" with cluster 5, size 1025, data_start 0x1000, spc_log2=2 -> requests 0x100C, 0x100D, 0x100E, then done with found=1.
REQ-039 Target absent, dir_done after 3 entries -> notfound=1, done=1, no rd_req.
REQ-040 Matching entry with size 0 -> found=1, done=1, zero requests; cluster 0 with size 10 -> err=1.
REQ-041 rd_ack delayed 7 cycles -> rd_req and rd_sector stay stable for all 7 cycles; stray rd_ack in SCAN -> no effect.
REQ-042 rst asserted during REQ of a 4-sector file -> rd_req=0 at once and state IDLE; a new start rescans correctly.
REQ-043 Matching fready and dir_done in the same cycle -> found=1, notfound=0.
